hazard_scoreboard: RTL

Parametrised operand-hazard unit for the pipelined CPU, sitting beside the decode stage. It owns a shadow pipeline of in-flight writer descriptors (dest register, write-enable, load flag) for DEPTH stages after decode. Each cycle it compares the decode instruction's source registers against that pipeline and produces a per-source forwarding select, a load-use stall, statistics and a stall watchdog. It handles N_SRC sources, any register-file size and any pipeline depth.

---
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Operand-hazard unit beside decode: tracks in-flight writers for DEPTH stages,
// selects the youngest forwarding source per operand, requests load-use stalls and watches stall length.
module hazard_scoreboard #(
    parameter int REG_ADDR_W         = 3,
    parameter int N_SRC              = 2,
    parameter int DEPTH              = 3,
    parameter int LOAD_READY         = 2,
    parameter int ZERO_REG_HARDWIRED = 0,
    parameter int CNT_W              = 16,
    parameter int MAX_STALL          = 8,
    parameter int SEL_W              = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        id_valid,
    input  logic [N_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [N_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]       id_dst_addr,
    input  logic                        id_dst_we,
    input  logic                        id_is_load,
    input  logic                        pipe_en,
    input  logic                        flush,
    input  logic                        stall_clr,
    output logic                        issue,
    output logic                        stall,
    output logic [N_SRC-1:0]            fwd_hit,
    output logic [N_SRC*SEL_W-1:0]      fwd_stage,
    output logic [DEPTH-1:0]            stage_valid,
    output logic [CNT_W-1:0]            stall_count,
    output logic                        wd_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);

    typedef enum logic {RUN, STALLED} state_t;

    state_t                  state;
    logic [RUN_W-1:0]        run_cnt;
    logic [DEPTH-1:0]        s_valid;
    logic [DEPTH-1:0]        s_we;
    logic [DEPTH-1:0]        s_ld;
    logic [REG_ADDR_W-1:0]   s_dst [DEPTH];
    logic [REG_ADDR_W-1:0]   src;
    logic                    hazard;
    logic                    adv;

    // Scan stages oldest-last so the first match found is the youngest producer.
    always_comb begin
        hazard    = 1'b0;
        fwd_hit   = '0;
        fwd_stage = '0;
        src       = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            src = id_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!fwd_hit[i] && id_src_used[i] && s_valid[k] && s_we[k] &&
                    (s_dst[k] == src) && !((ZERO_REG_HARDWIRED != 0) && (src == '0))) begin
                    fwd_hit[i]                   = 1'b1;
                    fwd_stage[i*SEL_W +: SEL_W]  = SEL_W'(k);
                    if (s_ld[k] && (int'(k) < LOAD_READY))
                        hazard = 1'b1;
                end
            end
        end
    end

    assign stall       = id_valid & hazard & ~flush;
    assign issue       = id_valid & ~stall & ~flush & pipe_en;
    assign adv         = pipe_en | flush;
    assign stage_valid = s_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_valid <= '0;
            s_we    <= '0;
            s_ld    <= '0;
            for (int unsigned k = 0; k < DEPTH; k++)
                s_dst[k] <= '0;
        end else if (adv) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                s_valid[k] <= s_valid[k-1];
                s_we[k]    <= s_we[k-1];
                s_ld[k]    <= s_ld[k-1];
                s_dst[k]   <= s_dst[k-1];
            end
            s_valid[0] <= issue;
            s_we[0]    <= id_dst_we;
            s_ld[0]    <= id_is_load;
            s_dst[0]   <= id_dst_addr;
        end
    end

    // wd_err fires on the edge where run_cnt reaches MAX_STALL, i.e. the MAX_STALL-th consecutive stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            run_cnt     <= '0;
            wd_err      <= 1'b0;
            stall_count <= '0;
        end else begin
            if (stall) begin
                state <= STALLED;
                if (run_cnt != RUN_W'(MAX_STALL))
                    run_cnt <= run_cnt + 1'b1;
            end else begin
                state <= RUN;
                if (state == STALLED)
                    run_cnt <= '0;
            end

            if (stall_clr)
                wd_err <= 1'b0;
            else if (stall && (run_cnt >= RUN_W'(MAX_STALL - 1)))
                wd_err <= 1'b1;

            if (stall_clr)
                stall_count <= '0;
            else if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule
